// File: rtl/matrix_entry_ctrl_pkg.sv
// Shared definitions for the matrix-entry controller slice.
//   - state_t      : session FSM state encoding
//   - header layout: rows in [7:4], cols in [3:0] of the slot header word
//   - storage geometry defaults (words per slot, slot count)
//   - hdr_word()   : packs rows/cols into a header word
package matrix_entry_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_GET_ROWS  = 3'd1,
      S_GET_COLS  = 3'd2,
      S_GET_ELEM  = 3'd3,
      S_WRITE_HDR = 3'd4,
      S_DONE      = 3'd5,
      S_ERROR     = 3'd6
   } state_t;

   localparam int HDR_FIELD_W  = 4;
   localparam int HDR_ROWS_LSB = 4;
   localparam int HDR_COLS_LSB = 0;

   localparam int DEF_SLOT_WORDS = 32;
   localparam int DEF_NUM_SLOTS  = 8;

   function automatic logic [31:0] hdr_word(input logic [3:0] r, input logic [3:0] c);
      logic [31:0] w;
      w = '0;
      w[HDR_ROWS_LSB +: HDR_FIELD_W] = r;
      w[HDR_COLS_LSB +: HDR_FIELD_W] = c;
      return w;
   endfunction

endpackage

// File: rtl/matrix_entry_ctrl_err_countdown.sv
// Error countdown: a tick prescaler of CLK_FREQ cycles driving a seconds
// down-counter. Shared by FSM error paths that show a visible countdown.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a countdown at SECS seconds
//   clear      : force the counter to 0 (takes priority over load)
//   busy       : countdown in progress (secs != 0)
//   secs       : seconds remaining
//   expire     : high in the last cycle of the countdown; secs reads 0 next cycle
module matrix_entry_ctrl_err_countdown #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int SECS     = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       clear,
   output logic       busy,
   output logic [3:0] secs,
   output logic       expire
);

   localparam int TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

   logic [TW-1:0] tick;
   logic          wrap;

   assign wrap   = (tick == TW'(CLK_FREQ - 1));
   assign busy   = (secs != 4'd0);
   assign expire = (secs == 4'd1) && wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick <= '0;
         secs <= 4'd0;
      end else if (clear) begin
         tick <= '0;
         secs <= 4'd0;
      end else if (load) begin
         tick <= '0;
         secs <= 4'(SECS);
      end else if (busy) begin
         if (wrap) begin
            tick <= '0;
            secs <= secs - 4'd1;
         end else begin
            tick <= tick + TW'(1);
         end
      end
   end

endmodule

// File: rtl/matrix_entry_ctrl.sv
// Matrix-entry session controller. Enables the UART number parser, takes
// rows, cols and rows*cols elements, writes the elements into the current
// storage slot and commits the slot with a header word. Bad input triggers
// a visible error countdown and then re-prompts the failed field.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort          : session control from the main FSM
//   num_valid, num_value  : parsed number from the parser
//   parse_err             : illegal character seen by the parser
//   parser_en             : parser enable (GET_ROWS/GET_COLS/GET_ELEM only)
//   mem_we/addr/data      : storage write port, one word per cycle
//   busy, done            : session active / slot committed pulse
//   err_active, err_secs  : error countdown status
//   cur_slot, valid_slots : slot in use / committed slot count (saturating)
module matrix_entry_ctrl
   import matrix_entry_ctrl_pkg::*;
#(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int MAX_DIM     = 5,
   parameter int MAX_VAL     = 9,
   parameter int ERR_SECONDS = 5,
   parameter int SLOT_WORDS  = DEF_SLOT_WORDS,
   parameter int NUM_SLOTS   = DEF_NUM_SLOTS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        num_valid,
   input  logic [31:0] num_value,
   input  logic        parse_err,
   output logic        parser_en,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [31:0] mem_data,
   output logic        busy,
   output logic        done,
   output logic        err_active,
   output logic [3:0]  err_secs,
   output logic [2:0]  cur_slot,
   output logic [3:0]  valid_slots
);

   state_t      state, state_nxt, ret, ret_nxt;
   logic [3:0]  rows, cols;
   logic [4:0]  idx;
   logic [2:0]  wr_ptr;
   logic [5:0]  total;
   logic        dim_ok, val_ok, last_elem;
   logic        latch_rows, latch_cols, elem_wr, hdr_wr, commit;
   logic        cd_load, cd_busy, cd_expire;
   logic [7:0]  base_addr, elem_addr;

   // Full 32-bit comparisons so oversized values can never alias into range.
   assign dim_ok    = (num_value >= 32'd1) && (num_value <= 32'(MAX_DIM));
   assign val_ok    = (num_value <= 32'(MAX_VAL));
   assign total     = {2'b00, rows} * {2'b00, cols};
   assign last_elem = ({1'b0, idx} == (total - 6'd1));

   assign base_addr = 8'(32'(cur_slot) * 32'(SLOT_WORDS));
   assign elem_addr = base_addr + 8'd1 + {3'b000, idx};

   assign hdr_wr  = (state == S_WRITE_HDR) && !abort;
   assign commit  = (state == S_DONE) && !abort;
   assign cd_load = (state_nxt == S_ERROR) && (state != S_ERROR);

   always_comb begin
      state_nxt  = state;
      ret_nxt    = ret;
      latch_rows = 1'b0;
      latch_cols = 1'b0;
      elem_wr    = 1'b0;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (start) state_nxt = S_GET_ROWS;
            S_GET_ROWS: begin
               if (parse_err || (num_valid && !dim_ok)) begin
                  state_nxt = S_ERROR;
                  ret_nxt   = S_GET_ROWS;
               end else if (num_valid) begin
                  latch_rows = 1'b1;
                  state_nxt  = S_GET_COLS;
               end
            end
            // A bad column count re-prompts both dimensions.
            S_GET_COLS: begin
               if (parse_err || (num_valid && !dim_ok)) begin
                  state_nxt = S_ERROR;
                  ret_nxt   = S_GET_ROWS;
               end else if (num_valid) begin
                  latch_cols = 1'b1;
                  state_nxt  = S_GET_ELEM;
               end
            end
            S_GET_ELEM: begin
               if (parse_err || (num_valid && !val_ok)) begin
                  state_nxt = S_ERROR;
                  ret_nxt   = S_GET_ELEM;
               end else if (num_valid) begin
                  elem_wr = 1'b1;
                  if (last_elem) state_nxt = S_WRITE_HDR;
               end
            end
            S_WRITE_HDR: state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            // Leave on the cycle the counter hits 0 so err_active and
            // err_secs drop together; !cd_busy is a safety exit only.
            S_ERROR: if (cd_expire || !cd_busy) state_nxt = ret;
            default:     state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         ret   <= S_IDLE;
      end else begin
         state <= state_nxt;
         ret   <= ret_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rows        <= 4'd0;
         cols        <= 4'd0;
         idx         <= 5'd0;
         wr_ptr      <= 3'd0;
         cur_slot    <= 3'd0;
         valid_slots <= 4'd0;
         parser_en   <= 1'b0;
         busy        <= 1'b0;
         err_active  <= 1'b0;
         done        <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 8'd0;
         mem_data    <= 32'd0;
      end else begin
         if (latch_rows) rows <= num_value[3:0];
         if (latch_cols) begin
            cols <= num_value[3:0];
            idx  <= 5'd0;
         end
         if (elem_wr) idx <= idx + 5'd1;
         if ((state == S_IDLE) && start && !abort) cur_slot <= wr_ptr;
         if (commit) begin
            wr_ptr <= (wr_ptr == 3'(NUM_SLOTS - 1)) ? 3'd0 : wr_ptr + 3'd1;
            if (valid_slots != 4'(NUM_SLOTS)) valid_slots <= valid_slots + 4'd1;
         end
         parser_en  <= (state_nxt == S_GET_ROWS) || (state_nxt == S_GET_COLS) ||
                       (state_nxt == S_GET_ELEM);
         busy       <= (state_nxt != S_IDLE);
         err_active <= (state_nxt == S_ERROR);
         done       <= hdr_wr;
         mem_we     <= elem_wr || hdr_wr;
         if (elem_wr) begin
            mem_addr <= elem_addr;
            mem_data <= num_value;
         end else if (hdr_wr) begin
            mem_addr <= base_addr;
            mem_data <= hdr_word(rows, cols);
         end
      end
   end

   matrix_entry_ctrl_err_countdown #(
      .CLK_FREQ (CLK_FREQ),
      .SECS     (ERR_SECONDS)
   ) u_countdown (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (cd_load),
      .clear  (abort),
      .busy   (cd_busy),
      .secs   (err_secs),
      .expire (cd_expire)
   );

endmodule

// File: tb/tb_matrix_entry_ctrl.sv
module tb_matrix_entry_ctrl;

   logic        clk, rst_n, start, abort, num_valid, parse_err;
   logic [31:0] num_value;
   logic        parser_en, mem_we, busy, done, err_active;
   logic [7:0]  mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  err_secs, valid_slots;
   logic [2:0]  cur_slot;

   matrix_entry_ctrl #(.CLK_FREQ(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .num_valid(num_valid), .num_value(num_value), .parse_err(parse_err),
      .parser_en(parser_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_data(mem_data), .busy(busy), .done(done), .err_active(err_active),
      .err_secs(err_secs), .cur_slot(cur_slot), .valid_slots(valid_slots)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] value;
      logic        perr;
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic        err;
   } vec_t;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   vec_t vec [0:33];
   wr_t  exp_q[$];
   int   checks = 0;
   int   passes = 0;

   function automatic vec_t mk(input logic [31:0] v, input logic pe, input logic wr,
                               input logic [7:0] a, input logic [31:0] d, input logic er);
      vec_t r;
      r.value = v; r.perr = pe; r.wr = wr; r.addr = a; r.data = d; r.err = er;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Scoreboard: every storage write must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (mem_addr === e.addr && mem_data === e.data) passes++;
            else $display("FAIL mem_write: got addr %0h data %0h, expected addr %0h data %0h",
                          mem_addr, mem_data, e.addr, e.data);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a; w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic send(input logic [31:0] v, input logic pe);
      num_valid = 1'b1; num_value = v; parse_err = pe;
      cyc();
      num_valid = 1'b0; parse_err = 1'b0;
   endtask

   task automatic run_vec(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (vec[i].wr) push(vec[i].addr, vec[i].data);
         send(vec[i].value, vec[i].perr);
         chk("vec_mem_we", 32'(mem_we), 32'(vec[i].wr));
         chk("vec_err_active", 32'(err_active), 32'(vec[i].err));
         chk("vec_err_secs", 32'(err_secs), vec[i].err ? 32'd5 : 32'd0);
         if (!vec[i].err) cyc();
      end
   endtask

   task automatic start_session(input logic [2:0] slot);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_parser_en", 32'(parser_en), 32'd1);
      chk("start_cur_slot", 32'(cur_slot), 32'(slot));
   endtask

   task automatic finish(input logic [7:0] ha, input logic [31:0] hd,
                         input int vs, input logic [2:0] slot);
      push(ha, hd);
      chk("done_pulse", 32'(done), 32'd1);
      chk("hdr_we", 32'(mem_we), 32'd1);
      cyc();
      chk("done_low", 32'(done), 32'd0);
      chk("valid_slots", 32'(valid_slots), 32'(vs));
      chk("cur_slot", 32'(cur_slot), 32'(slot));
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic wait_clear();
      int n = 0;
      while (err_active && n < 200) begin
         cyc();
         n++;
      end
      chk("err_clear", 32'(err_active), 32'd0);
      chk("err_parser_en", 32'(parser_en), 32'd1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_parser_en"}, 32'(parser_en), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_data"}, mem_data, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err_active"}, 32'(err_active), 32'd0);
      chk({tag, "_err_secs"}, 32'(err_secs), 32'd0);
      chk({tag, "_cur_slot"}, 32'(cur_slot), 32'd0);
      chk({tag, "_valid_slots"}, 32'(valid_slots), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // session 1: 2x3 into slot 0
      vec[0]  = mk(2, 0, 0, 8'h00, 0, 0);
      vec[1]  = mk(3, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 6; i++) vec[2+i] = mk(32'(i+1), 0, 1, 8'(i+1), 32'(i+1), 0);
      // rows=7 out of range
      vec[8]  = mk(7, 0, 0, 8'h00, 0, 1);
      vec[9]  = mk(1, 0, 0, 8'h00, 0, 0);
      vec[10] = mk(1, 0, 0, 8'h00, 0, 0);
      vec[11] = mk(9, 0, 1, 8'h21, 9, 0);
      // 2x2 with a bad third element
      vec[12] = mk(2, 0, 0, 8'h00, 0, 0);
      vec[13] = mk(2, 0, 0, 8'h00, 0, 0);
      vec[14] = mk(1, 0, 1, 8'h41, 1, 0);
      vec[15] = mk(2, 0, 1, 8'h42, 2, 0);
      vec[16] = mk(12, 0, 0, 8'h00, 0, 1);
      vec[17] = mk(4, 0, 1, 8'h43, 4, 0);
      vec[18] = mk(5, 0, 1, 8'h44, 5, 0);
      // 1x2 with parse_err colliding with num_valid
      vec[19] = mk(1, 0, 0, 8'h00, 0, 0);
      vec[20] = mk(2, 0, 0, 8'h00, 0, 0);
      vec[21] = mk(5, 1, 0, 8'h00, 0, 1);
      vec[22] = mk(5, 0, 1, 8'h61, 5, 0);
      vec[23] = mk(6, 0, 1, 8'h62, 6, 0);
      // 2x2 aborted after two elements
      vec[24] = mk(2, 0, 0, 8'h00, 0, 0);
      vec[25] = mk(2, 0, 0, 8'h00, 0, 0);
      vec[26] = mk(1, 0, 1, 8'h81, 1, 0);
      vec[27] = mk(2, 0, 1, 8'h82, 2, 0);
      // bad cols re-prompts rows
      vec[28] = mk(2, 0, 0, 8'h00, 0, 0);
      vec[29] = mk(6, 0, 0, 8'h00, 0, 1);
      vec[30] = mk(1, 0, 0, 8'h00, 0, 0);
      vec[31] = mk(1, 0, 0, 8'h00, 0, 0);
      vec[32] = mk(3, 0, 1, 8'h81, 3, 0);
      // all-ones rows value
      vec[33] = mk(32'hFFFF_FFFF, 0, 0, 8'h00, 0, 1);

      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      num_valid = 1'b0; num_value = 32'd0; parse_err = 1'b0;
      cyc(); cyc();
      check_zero("reset");
      rst_n = 1'b1;
      cyc();

      start_session(3'd0);
      run_vec(0, 7);
      finish(8'h00, 32'h23, 1, 3'd0);

      start_session(3'd1);
      run_vec(8, 8);
      for (int c = 0; c < 50; c++) begin
         chk("countdown_secs", 32'(err_secs), 32'(5 - c / 10));
         chk("countdown_active", 32'(err_active), 32'd1);
         if (c == 20) begin
            num_valid = 1'b1; num_value = 32'd3;
         end
         cyc();
         num_valid = 1'b0;
      end
      chk("countdown_end_active", 32'(err_active), 32'd0);
      chk("countdown_end_secs", 32'(err_secs), 32'd0);
      chk("countdown_end_parser_en", 32'(parser_en), 32'd1);
      run_vec(9, 11);
      finish(8'h20, 32'h11, 2, 3'd1);

      start_session(3'd2);
      run_vec(12, 16);
      wait_clear();
      run_vec(17, 18);
      finish(8'h40, 32'h22, 3, 3'd2);

      start_session(3'd3);
      run_vec(19, 21);
      wait_clear();
      run_vec(22, 23);
      finish(8'h60, 32'h12, 4, 3'd3);

      start_session(3'd4);
      run_vec(24, 27);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_parser_en", 32'(parser_en), 32'd0);
      chk("abort_mem_we", 32'(mem_we), 32'd0);
      chk("abort_valid_slots", 32'(valid_slots), 32'd4);
      cyc();
      start_session(3'd4);
      run_vec(28, 29);
      wait_clear();
      run_vec(30, 32);
      finish(8'h80, 32'h11, 5, 3'd4);

      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      for (int s = 0; s < 9; s++) begin
         start_session(3'(s % 8));
         send(1, 0); cyc();
         send(1, 0); cyc();
         push(8'((s % 8) * 32 + 1), 32'(s));
         send(32'(s), 0); cyc();
         finish(8'((s % 8) * 32), 32'h11, (s + 1 > 8) ? 8 : s + 1, 3'(s % 8));
      end

      start_session(3'd1);
      run_vec(33, 33);
      cyc(); cyc(); cyc();
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      #3 rst_n = 1'b1;
      cyc();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/matrix_entry_ctrl.md
Name: matrix_entry_ctrl

Overview:
Sequences one matrix-entry session on top of the UART number parser.
- Enables the parser and takes the number stream: rows, cols, then rows*cols elements.
- Validates each value and writes the elements into a slot of matrix storage.
- Commits the slot with a header word. On bad input it runs a visible error countdown, then re-prompts the failed field.
- Sits between the main FSM (start/abort/done) and the storage write MUX.

Parameters:
CLK_FREQ, 100_000_000, clk cycles per countdown second
MAX_DIM, 5, largest legal rows/cols (min is 1)
MAX_VAL, 9, largest legal element value (min is 0)
ERR_SECONDS, 5, error countdown length in seconds (1..15)
SLOT_WORDS, 32, storage words per slot; must be ≥ MAX_DIM*MAX_DIM+1
NUM_SLOTS, 8, slots in storage; slot base = slot*SLOT_WORDS

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse from main FSM: begin session (ignored unless IDLE)
abort  in  1  level/pulse: drop session, return to IDLE, no commit
num_valid  in  1  parser pulse: num_value holds a complete number
num_value  in  32  parsed unsigned number
parse_err  in  1  parser pulse: illegal character received
parser_en  out  1  enable to parser; high only in GET_ROWS/GET_COLS/GET_ELEM
mem_we  out  1  storage write strobe (one cycle per word)
mem_addr  out  8  storage word address
mem_data  out  32  storage write data
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the slot is committed
err_active  out  1  high during ERROR state
err_secs  out  4  seconds remaining in countdown; 0 outside ERROR
cur_slot  out  3  slot being filled / last committed
valid_slots  out  4  committed slot count, saturates at NUM_SLOTS

Behaviour:
- Reset (async): state IDLE; all outputs 0; wr_ptr=0; rows=cols=idx=0; tick/sec counters 0.
- All outputs are registered. mem_we/addr/data assert exactly 1 cycle after the accepted num_valid.
- States: IDLE, GET_ROWS, GET_COLS, GET_ELEM, WRITE_HDR, DONE, ERROR.
- IDLE: on start -> GET_ROWS; cur_slot<=wr_ptr.
- GET_ROWS: on num_valid with 1≤value≤MAX_DIM, latch rows -> GET_COLS; otherwise -> ERROR with ret=GET_ROWS.
- GET_COLS: legal value -> latch cols, idx<=0 -> GET_ELEM; illegal -> ERROR with ret=GET_ROWS (both dims are re-entered).
- GET_ELEM: on num_valid with value≤MAX_VAL:
  - write mem_addr=cur_slot*SLOT_WORDS+1+idx, mem_data=value; idx++.
  - when idx==rows*cols-1 -> WRITE_HDR.
  - illegal value -> ERROR with ret=GET_ELEM; idx is unchanged and nothing is written.
- WRITE_HDR: one cycle.
  - write mem_addr=cur_slot*SLOT_WORDS, mem_data={24'b0,rows[3:0],cols[3:0]}.
  - -> DONE.
- DONE: done=1 for one cycle; wr_ptr<=wr_ptr+1 mod NUM_SLOTS (wraps 7->0, overwriting the oldest slot); valid_slots++ (saturating) -> IDLE.
- ERROR:
  - parser_en=0, so input is discarded.
  - err_secs loads ERR_SECONDS on entry; tick counter counts CLK_FREQ cycles per decrement.
  - When err_secs reaches 0 -> ret state, err_active drops the same cycle.
- parse_err in any GET_* state -> ERROR with ret equal to the current field (ret=GET_ROWS if the state is GET_COLS).
- Priority: abort > parse_err > num_valid. Simultaneous parse_err and num_valid: the number is dropped and the error is taken.
- abort in any state -> IDLE next cycle:
  - elements already written stay in storage, but no header is written, so the slot remains uncommitted.
  - wr_ptr and valid_slots are unchanged; err_secs<=0.
- start while busy is ignored. num_valid/parse_err in IDLE/WRITE_HDR/DONE are ignored.
- Width rules:
  - value comparisons use the full 32 bits, so 2^32-1 is illegal.
  - rows*cols is a 6-bit product; idx is 5 bits.
  - address math is truncated to 8 bits.

Decomposition:
- Shared package: state encoding constants, header field layout (rows at [7:4], cols at [3:0]), SLOT_WORDS/NUM_SLOTS defaults.
- One natural sub-module, err_countdown: tick prescaler plus seconds down-counter with load/busy/secs ports. It is reused by other FSM error paths.

Test Plan:
(Bench uses CLK_FREQ=10.)
1. start; values 2,3,1,2,3,4,5,6 -> writes addr 1..6 with data 1..6, then addr 0 data 0x23; done pulse; valid_slots=1; cur_slot=0.
2. start; rows=7 -> err_active=1, err_secs runs 5..1 over 50 cycles, then GET_ROWS; re-enter 1,1,9 -> addr 0x21=9, addr 0x20=0x11.
3. 2x2 session; third element 12 -> ERROR, no write; after countdown send 4 -> written at base+3 (idx retained); completes normally.
4. parse_err and num_valid in the same cycle in GET_ELEM -> no mem_we, ERROR entered.
5. abort after 2 of 4 elements -> IDLE next cycle; no header write; next start reuses the same slot; valid_slots unchanged.
6. Nine back-to-back 1x1 sessions -> ninth writes slot 0 (addr 0x00/0x01); valid_slots saturates at 8. Assert rst_n mid-ERROR -> all outputs 0 immediately.
